uart_frame_loader: RTL and testbench

Parametrised UART frame loader for the CNN input path: receives a start-byte-delimited frame of `FRAME_LEN` bytes from the UART receiver and writes it into a two-bank (ping-pong) input BRAM. It hands each completed bank to the convolution control unit through a ready/release handshake, so the next image can stream in while the current one is processed. It is the generalised replacement for the fixed 64-byte, single-buffer receive FSM at the top level, adding per-byte timeout, overrun detection and an optional checksum.

---
 rtl/loader_pkg.sv | 14 +
 rtl/pingpong_bank_ctrl.sv | 44 ++++
 rtl/uart_frame_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_frame_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the UART frame loader.
// State encoding and default frame delimiter.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT
  } loader_state_t;

  localparam logic [7:0] DEF_START_BYTE = 8'h01;

endpackage

// File: rtl/pingpong_bank_ctrl.sv
// Two-bank full/empty tracking with commit (producer)
// and release (consumer) ports.
module pingpong_bank_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic frame_release,
  output logic wr_bank,
  output logic wr_full,
  output logic frame_rdy,
  output logic frame_bank
);

  logic [1:0] full;
  logic [1:0] full_n;
  logic       rd_bank;
  logic       rel;

  assign rel = frame_release && full[rd_bank];

  // commit and release never hit the same bank
  always_comb begin
    full_n = full;
    if (commit) full_n[wr_bank] = 1'b1;
    if (rel)    full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_n;
      if (commit) wr_bank <= ~wr_bank;
      if (rel)    rd_bank <= ~rd_bank;
    end
  end

  assign wr_full    = full[wr_bank];
  assign frame_rdy  = full[rd_bank];
  assign frame_bank = rd_bank;

endmodule

// File: rtl/uart_frame_loader.sv
// UART frame loader into a ping-pong input BRAM.
// Optional trailing checksum byte: FRAME_CHECKSUM_EN.
module uart_frame_loader
  import loader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = $clog2(FRAME_LEN),
  parameter logic [DATA_W-1:0] START_BYTE =
    DATA_W'(DEF_START_BYTE),
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_rdy,
  output logic              frame_bank,
  input  logic              frame_release,
  output logic              loading,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              err_checksum
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(TIMEOUT_CYCLES);

`ifdef FRAME_CHECKSUM_EN
  localparam loader_state_t AFTER_PAY = CHECK;
`else
  localparam loader_state_t AFTER_PAY = COMMIT;
`endif

  loader_state_t     state;
  loader_state_t     state_n;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              accept;
  logic              commit;
  logic              ovr;
  logic              tmo;
  logic              tmo_hit;
  logic              in_frame_n;
  logic              wr_bank;
  logic              wr_full;

  assign tmo_hit = (cnt == TMO);
  assign in_frame_n = (state_n == LOAD) ||
                      (state_n == CHECK);

`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              ck_err;
`endif

  always_comb begin
    state_n = state;
    start   = 1'b0;
    accept  = 1'b0;
    commit  = 1'b0;
    ovr     = 1'b0;
    tmo     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    ck_err  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (rx_ready && rx_data == START_BYTE) begin
          if (wr_full) begin
            ovr = 1'b1;
          end else begin
            start   = 1'b1;
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (rx_ready) begin
          accept = 1'b1;
          if (idx == LAST) state_n = AFTER_PAY;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CHECK: begin
        if (rx_ready) begin
          if (rx_data == sum) begin
            state_n = COMMIT;
          end else begin
            ck_err  = 1'b1;
            state_n = IDLE;
          end
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      wr_en       <= accept;
      err_timeout <= tmo;
      err_overrun <= ovr;
      if (start) idx <= '0;
      else if (accept) idx <= idx + 1'b1;
      // idle gap counter, live only inside a frame
      if (rx_ready || !in_frame_n) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (accept) begin
        wr_addr <= {wr_bank, idx};
        wr_data <= rx_data;
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum          <= '0;
      err_checksum <= 1'b0;
    end else begin
      err_checksum <= ck_err;
      if (start) sum <= '0;
      else if (accept) sum <= sum + rx_data;
    end
  end
`else
  assign err_checksum = 1'b0;
`endif

  assign loading = (state != IDLE);

  pingpong_bank_ctrl u_banks (
    .clk           (clk),
    .reset         (reset),
    .commit        (commit),
    .frame_release (frame_release),
    .wr_bank       (wr_bank),
    .wr_full       (wr_full),
    .frame_rdy     (frame_rdy),
    .frame_bank    (frame_bank)
  );

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader with a
// frame-level reference model of the two banks.
module tb_uart_frame_loader;
  import loader_pkg::*;

  localparam int FL  = 64;
  localparam int AW  = 6;
  localparam int TMO = 200;
  localparam logic [7:0] SB = DEF_START_BYTE;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_ready = 1'b0;
  logic       frame_release = 1'b0;
  logic       wr_en;
  logic [AW:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_rdy;
  logic       frame_bank;
  logic       loading;
  logic       err_timeout;
  logic       err_overrun;
  logic       err_checksum;

  uart_frame_loader #(
    .FRAME_LEN      (FL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_rdy     (frame_rdy),
    .frame_bank    (frame_bank),
    .frame_release (frame_release),
    .loading       (loading),
    .err_timeout   (err_timeout),
    .err_overrun   (err_overrun),
    .err_checksum  (err_checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW:0] addr;
    logic [7:0]  data;
    int          c;
  } wr_t;

  wr_t exp_q[$];
  wr_t got;
  int  n_chk = 0;
  int  n_fail = 0;
  int  n_ovr = 0;
  int  n_tmo = 0;
  int  n_ck = 0;
  int  n_ovr_exp = 0;
  int  n_ck_exp = 0;

  // reference model: bank occupancy and pointers
  bit         full_m[2];
  bit         wb_m = 1'b0;
  bit         rb_m = 1'b0;
  logic [7:0] pay[FL];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // monitor: pops the write scoreboard, counts pulses
  always @(negedge clk) begin
    if (reset) begin
      if (err_overrun) n_ovr++;
      if (err_timeout) n_tmo++;
      if (err_checksum) n_ck++;
      if (wr_en) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: addr %0h data %0h",
                   wr_addr, wr_data);
        end else begin
          got = exp_q.pop_front();
          if (wr_addr !== got.addr ||
              wr_data !== got.data ||
              cyc != got.c + 1) begin
            n_fail++;
            $display("FAIL wr: got %0h/%0h @%0d want %0h/%0h @%0d",
                     wr_addr, wr_data, cyc,
                     got.addr, got.data, got.c + 1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic expect_wr(input int i);
    wr_t w;
    w.addr = {wb_m, AW'(i)};
    w.data = pay[i];
    w.c    = cyc;
    exp_q.push_back(w);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < FL; i++) begin
      pay[i] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) pay[i] = SB;
    end
  endtask

  task automatic overrun();
    int n0;
    n0 = n_ovr;
    strobe(SB);
    idle(1);
    #1;
    check("overrun_pulse", n_ovr - n0, 1);
    check("overrun_loading", loading, 0);
    idle(2);
    #1;
    check("overrun_single", n_ovr - n0, 1);
    n_ovr_exp++;
  endtask

  task automatic release_frame();
    @(negedge clk);
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
    if (full_m[rb_m]) begin
      full_m[rb_m] = 1'b0;
      rb_m = ~rb_m;
    end
    #1;
    check("rel_rdy", frame_rdy, full_m[rb_m]);
    check("rel_bank", frame_bank, rb_m);
  endtask

  task automatic send_frame(input bit bad,
                            input bit rel_c,
                            input bit chk_t);
    logic [7:0] s;
    bit pre;
    bit commits;
    int n0;
    if (full_m[wb_m]) begin
      overrun();
      return;
    end
    strobe(SB);
    s = '0;
    for (int i = 0; i < FL; i++) begin
      strobe(pay[i]);
      expect_wr(i);
      s = s + pay[i];
    end
    commits = 1'b1;
    n0 = n_ck;
`ifdef FRAME_CHECKSUM_EN
    strobe(bad ? s + 8'd1 : s);
    commits = !bad;
`endif
    pre = full_m[rb_m];
    @(negedge clk);
    rx_ready = 1'b0;
    frame_release = rel_c;
    check("rdy_at_commit", frame_rdy, pre);
    if (chk_t) check("loading_at_commit", loading, commits);
    @(negedge clk);
    frame_release = 1'b0;
    if (rel_c && full_m[rb_m]) begin
      full_m[rb_m] = 1'b0;
      rb_m = ~rb_m;
    end
    if (commits) begin
      full_m[wb_m] = 1'b1;
      wb_m = ~wb_m;
    end
    #1;
    check("frame_rdy", frame_rdy, full_m[rb_m]);
    check("frame_bank", frame_bank, rb_m);
    check("loading_done", loading, 0);
    check("ck_pulse", n_ck - n0, !commits);
    if (!commits) n_ck_exp++;
  endtask

  initial begin
    int k;
    full_m[0] = 1'b0;
    full_m[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_frame_rdy", frame_rdy, 0);
    check("rst_loading", loading, 0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_bank", frame_bank, 0);
    check("post_rst_errs",
          {err_timeout, err_overrun, err_checksum}, 0);

    // incrementing payload into bank 0, exact timing
    for (int i = 0; i < FL; i++) pay[i] = 8'(i);
    send_frame(1'b0, 1'b0, 1'b1);

    // stray bytes in IDLE are ignored
    strobe(8'h55);
    strobe(8'hA0);
    idle(2);
    #1;
    check("stray_loading", loading, 0);

    // second frame lands in bank 1, start byte in data
    fill_rand();
    pay[5] = SB;
    send_frame(1'b0, 1'b0, 1'b0);

    // both banks full
    overrun();
    release_frame();

    // timeout after 10 bytes into bank 0
    fill_rand();
    strobe(SB);
    for (int i = 0; i < 10; i++) begin
      strobe(pay[i]);
      expect_wr(i);
    end
    idle(1);
    k = n_tmo;
    repeat (TMO - 5) @(negedge clk);
    #1;
    check("no_early_tmo", n_tmo, k);
    check("tmo_loading", loading, 1);
    k = 0;
    while (k < 20 && n_tmo == 0) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("tmo_pulse", n_tmo, 1);
    check("tmo_latency", (k >= 4 && k <= 8), 1);
    check("tmo_loading_off", loading, 0);
    check("tmo_rdy", frame_rdy, full_m[rb_m]);

    // refill bank 0 while releasing bank 1 at commit
    fill_rand();
    send_frame(1'b0, 1'b1, 1'b1);
    release_frame();

    // reset in the middle of a frame
    fill_rand();
    strobe(SB);
    for (int i = 0; i < 30; i++) begin
      strobe(pay[i]);
      expect_wr(i);
    end
    idle(1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_loading", loading, 0);
    check("midrst_rdy", frame_rdy, 0);
    check("midrst_bank", frame_bank, 0);
    exp_q.delete();
    full_m[0] = 1'b0;
    full_m[1] = 1'b0;
    wb_m = 1'b0;
    rb_m = 1'b0;
    idle(2);
    reset = 1'b1;
    fill_rand();
    send_frame(1'b0, 1'b0, 1'b0);

    // random mix of frames, releases and overruns
    repeat (8) begin
      if ($urandom_range(0, 2) == 0) begin
        release_frame();
      end else begin
        fill_rand();
        send_frame(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

`ifdef FRAME_CHECKSUM_EN
    release_frame();
    release_frame();
    for (int i = 0; i < FL; i++) pay[i] = 8'h02;
    send_frame(1'b0, 1'b0, 1'b1);
    release_frame();
    send_frame(1'b1, 1'b0, 1'b1);
    check("ck_bad_no_rdy", frame_rdy, 0);
`endif

    idle(3);
    #1;
    check("ovr_total", n_ovr, n_ovr_exp);
    check("tmo_total", n_tmo, 1);
    check("ck_total", n_ck, n_ck_exp);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
